// File: rtl/led_box_pkg.sv
// -----------------------------------------------------------------------------
// led_box_pkg
// Shared constants and width helpers for the debugger panel LED driver.
//   DEF_TICK_DIV      : default clocks per timebase tick (1 ms at 50 MHz)
//   DEF_STRETCH_TICKS : default ticks an LED stays lit after an event pulse
//   DEF_BLINK_TICKS   : default ticks per blink half-period
//   clog2()           : ceiling log2, usable in constant expressions
//   min_one_width()   : clog2() clamped to at least one bit
// -----------------------------------------------------------------------------
package led_box_pkg;

  localparam int DEF_TICK_DIV      = 32'sd50000;
  localparam int DEF_STRETCH_TICKS = 32'sd100;
  localparam int DEF_BLINK_TICKS   = 32'sd250;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  // Counter width for a modulo-'value' counter, never narrower than one bit.
  function automatic int min_one_width(input int value);
    return (clog2(value) < 32'sd1) ? 32'sd1 : clog2(value);
  endfunction

endpackage

// File: rtl/led_box_pstrc01a.sv
// -----------------------------------------------------------------------------
// pstrc01a - pulse stretcher for one LED channel
// Turns a single-cycle event pulse into an on-time of STRETCH_TICKS timebase
// ticks. A trigger while stretching reloads the count, and a trigger always
// wins over a tick in the same cycle.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   tick  : one-cycle timebase strobe from the shared prescaler
//   trig  : event pulse; every high cycle (re)starts the stretch
//   on    : next-state "stretching" flag. It is combinational so that the
//           parent's registered LED lights in the cycle after the trigger.
// -----------------------------------------------------------------------------
module pstrc01a
  import led_box_pkg::*;
#(
  parameter int STRETCH_TICKS = DEF_STRETCH_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic trig,
  output logic on
);

  localparam int CNT_W = clog2(STRETCH_TICKS + 32'sd1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_STRETCH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State and tick-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load or reload on trig, count down on tick otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_STRETCH;
          cnt_d   = CNT_W'(STRETCH_TICKS);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_STRETCH: begin
        if (trig) begin
          state_d = ST_STRETCH;
          cnt_d   = CNT_W'(STRETCH_TICKS);
        end else if (tick) begin
          // The last tick of the stretch returns to idle instead of reaching 0.
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_STRETCH;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = ST_STRETCH;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign on = (state_d == ST_STRETCH);

endmodule

// File: rtl/led_box.sv
// -----------------------------------------------------------------------------
// led_box - debugger panel indicator LED driver
// Drives four LEDs from event pulses (stretched to a visible on-time) and level
// requests (steady or blinking). All timing comes from one free-running
// prescaler tick, and every output is registered.
// Ports:
//   clk           : system clock, the only clock
//   reset         : synchronous active-high reset
//   trig1..trig4  : single-cycle event pulses, one per channel
//   hold1..hold4  : level requests, LED on while high
//   blink         : while high, hold-driven LEDs blink instead of staying on
//   led1..led4    : registered LED drives, active-high
//   active        : registered OR of led1..led4
// -----------------------------------------------------------------------------
module led_box
  import led_box_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int STRETCH_TICKS = DEF_STRETCH_TICKS,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic trig1,
  input  logic trig2,
  input  logic trig3,
  input  logic trig4,
  input  logic hold1,
  input  logic hold2,
  input  logic hold3,
  input  logic hold4,
  input  logic blink,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic active
);

  localparam int PRESC_W = min_one_width(TICK_DIV);
  localparam int BLINK_W = min_one_width(BLINK_TICKS);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         led_q, led_d;
  logic               active_q, active_d;
  logic               tick;
  logic [3:0]         trig_v;
  logic [3:0]         hold_v;
  logic [3:0]         stretch_on;
  logic               hold_gate;

  assign trig_v = {trig4, trig3, trig2, trig1};
  assign hold_v = {hold4, hold3, hold2, hold1};
  assign tick   = (presc_q == PRESC_W'(TICK_DIV - 32'sd1));

  // Four independent pulse stretchers sharing the timebase tick.
  for (genvar ch = 0; ch < 4; ch++) begin : g_chan
    pstrc01a #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_pstrc (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .trig (trig_v[ch]),
      .on   (stretch_on[ch])
    );
  end

  // Free-running prescaler next state; wraps on the tick cycle.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Blink timebase: parked in the on phase while blink is low so every
  // blink period starts lit.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (bcnt_q == BLINK_W'(BLINK_TICKS - 32'sd1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BLINK_W'(1);
        phase_d = phase_q;
      end
    end else begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
    end
  end

  // LED equation: blink only gates the hold path, never a running stretch.
  always_comb begin
    hold_gate = ~blink | phase_q;
    led_d     = stretch_on | (hold_v & {4{hold_gate}});
    active_d  = |led_d;
  end

  // Timebase and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      led_q    <= 4'b0000;
      active_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      active_q <= active_d;
    end
  end

  assign led1   = led_q[0];
  assign led2   = led_q[1];
  assign led3   = led_q[2];
  assign led4   = led_q[3];
  assign active = active_q;

endmodule
